// File: rtl/event_pulse_detector.sv
// Event-stream monitor: registered strobes for programmable code matches, any
// non-null event and heartbeat, plus a heartbeat-loss watchdog level.
module event_pulse_detector #(
    parameter int         CLK_FREQUENCY  = 125000000,
    parameter int         MATCH_COUNT    = 4,
    parameter logic [7:0] HEARTBEAT_CODE = 8'h7A,
    parameter int         TIMEOUT_MS     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               eventCode,
    input  logic [8*MATCH_COUNT-1:0] matchCodes,
    input  logic [MATCH_COUNT-1:0]   matchEnable,
    output logic [MATCH_COUNT-1:0]   matchPulse,
    output logic                     anyEventPulse,
    output logic                     heartbeatPulse,
    output logic                     heartbeatTimeout,
    output logic [15:0]              eventCount
);

    localparam int N = $rtoi((CLK_FREQUENCY / 1.0e3) * TIMEOUT_MS);
    localparam int WD_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(N - 1);

    typedef enum logic {
        ARMED     = 1'b0,
        TIMED_OUT = 1'b1
    } wd_state_t;

    wd_state_t              state;
    wd_state_t              state_next;
    logic [WD_W-1:0]        wdCount;
    logic [WD_W-1:0]        wd_next;
    logic                   is_event;
    logic                   is_heartbeat;
    logic [MATCH_COUNT-1:0] hit;

    // Null code can never hit a slot, even one programmed to 8'h00.
    always_comb begin
        is_event     = (eventCode != 8'h00);
        is_heartbeat = (eventCode == HEARTBEAT_CODE);
        hit          = '0;
        for (int k = 0; k < MATCH_COUNT; k++) begin
            hit[k] = matchEnable[k] && is_event &&
                     (eventCode == matchCodes[8*k +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matchPulse     <= '0;
            anyEventPulse  <= 1'b0;
            heartbeatPulse <= 1'b0;
            eventCount     <= 16'd0;
        end else begin
            matchPulse     <= hit;
            anyEventPulse  <= is_event;
            heartbeatPulse <= is_heartbeat;
            if (is_event) begin
                eventCount <= eventCount + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ARMED;
            wdCount          <= WD_RELOAD;
            heartbeatTimeout <= 1'b0;
        end else begin
            state            <= state_next;
            wdCount          <= wd_next;
            heartbeatTimeout <= (state_next == TIMED_OUT);
        end
    end

    // A heartbeat on the cycle the counter reaches zero wins over the timeout.
    always_comb begin
        state_next = state;
        wd_next    = wdCount;
        case (state)
            ARMED: begin
                if (is_heartbeat) begin
                    wd_next = WD_RELOAD;
                end else if (wdCount == '0) begin
                    state_next = TIMED_OUT;
                end else begin
                    wd_next = wdCount - WD_W'(1);
                end
            end
            TIMED_OUT: begin
                if (is_heartbeat) begin
                    wd_next    = WD_RELOAD;
                    state_next = ARMED;
                end else begin
                    wd_next = '0;
                end
            end
        endcase
    end

endmodule
